lsu_split: RTL and testbench

LSU_SPLIT -- requirements
Module: lsu_split

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 36 +++
 rtl/lsu_split.sv | 152 +++++++++++++++
 tb/tb_lsu_split.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the split load/store unit: memop encodings,
// FSM state enum and the access-size lane mask helper.
package lsu_pkg;

  typedef enum logic [2:0] {
    MOP_B  = 3'b000,
    MOP_H  = 3'b001,
    MOP_W  = 3'b010,
    MOP_BU = 3'b100,
    MOP_HU = 3'b101
  } memop_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_ISSUE1,
    S_WAIT,
    S_DONE
  } state_e;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic memop_legal(input logic [2:0] op);
    case (op)
      MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane shifter: byte-lane mask and store data placement for
// both words of a (possibly split) access, plus load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  mask,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] load_data
);

  logic [4:0]  shift;
  logic [63:0] wide;
  logic [31:0] rsh;
  logic        sext;

  always_comb begin
    shift     = {offset, 3'b000};
    wide      = {32'b0, wdata} << shift;
    wdata_lo  = wide[31:0];
    wdata_hi  = wide[63:32];
    mask      = {4'b0000, size_mask(memop[1:0])} << offset;
    rsh       = 32'(rdata >> shift);
    sext      = ~memop[2];
    case (memop[1:0])
      2'b00:   load_data = {{24{sext & rsh[7]}}, rsh[7:0]};
      2'b01:   load_data = {{16{sext & rsh[15]}}, rsh[15:0]};
      default: load_data = rsh;
    endcase
  end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit that splits misaligned accesses crossing a word boundary
// into two single-word memory transactions and merges the load result.
module lsu_split
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_memop,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state;
  logic              we_q;
  logic [2:0]        memop_q;
  logic [MEM_AW+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data0_q;

  logic [2:0]        sel_memop;
  logic [1:0]        sel_offset;
  logic [31:0]       sel_wdata;
  logic [63:0]       sel_rdata;
  logic [7:0]        mask;
  logic [31:0]       wdata_lo;
  logic [31:0]       wdata_hi;
  logic [31:0]       load_data;
  logic              split;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:MEM_AW+2];
  assign req_ready = (state == S_IDLE);

  // In IDLE the aligner works on the incoming request so the first memory
  // beat can be registered on the accept edge.
  assign sel_memop  = (state == S_IDLE) ? req_memop     : memop_q;
  assign sel_offset = (state == S_IDLE) ? req_addr[1:0] : addr_q[1:0];
  assign sel_wdata  = (state == S_IDLE) ? req_wdata     : wdata_q;
  assign split      = |mask[7:4];
  assign sel_rdata  = split ? {mem_rdata, data0_q} : {32'b0, mem_rdata};

  lsu_align u_align (
    .memop     (sel_memop),
    .offset    (sel_offset),
    .wdata     (sel_wdata),
    .rdata     (sel_rdata),
    .mask      (mask),
    .wdata_lo  (wdata_lo),
    .wdata_hi  (wdata_hi),
    .load_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      memop_q    <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'b0;
      data0_q    <= 32'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'b0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            memop_q <= req_memop;
            addr_q  <= req_addr[MEM_AW+1:0];
            wdata_q <= req_wdata;
            if (!memop_legal(req_memop)) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'b0;
            end else begin
              state     <= S_ISSUE0;
              mem_addr  <= req_addr[MEM_AW+1:2];
              mem_be    <= mask[3:0];
              mem_wdata <= wdata_lo;
              mem_re    <= ~req_we;
              mem_we    <= req_we;
            end
          end
        end
        S_ISSUE0: begin
          if (split) begin
            state     <= S_ISSUE1;
            mem_addr  <= mem_addr + MEM_AW'(1);
            mem_be    <= mask[7:4];
            mem_wdata <= wdata_hi;
          end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 4'b0000;
            if (we_q) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_ISSUE1: begin
          mem_re  <= 1'b0;
          mem_we  <= 1'b0;
          mem_be  <= 4'b0000;
          data0_q <= mem_rdata;
          if (we_q) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          state      <= S_DONE;
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
        end
        S_DONE: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
// Directed self-checking bench for lsu_split with a lane-aware word memory model.
module tb_lsu_split;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_memop = 3'b000;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [14:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'b0;

  logic [31:0] mem [0:32767];
  int checks = 0;
  int errors = 0;

  lsu_split #(.MEM_AW(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_memop  (req_memop),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single accept edge; returns in cycle T+1.
  task automatic send(input logic we, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_memop = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_valid got %b exp 0", resp_valid); end
    checks++; if ({mem_re, mem_we} !== 2'b00) begin errors++; $display("[TB] FAIL rst_strobes got %b exp 00", {mem_re, mem_we}); end
    checks++; if (mem_be !== 4'b0000) begin errors++; $display("[TB] FAIL rst_be got %b exp 0000", mem_be); end
  endtask

  task automatic test_aligned_lw();
    mem[15'h40] = 32'h89ABCDEF;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL lw_ready got %b exp 1", req_ready); end
    send(1'b0, 3'b010, 32'h100, 32'h0);
    checks++; if ({mem_re, mem_we} !== 2'b10) begin errors++; $display("[TB] FAIL lw_strobes got %b exp 10", {mem_re, mem_we}); end
    checks++; if (mem_addr !== 15'h40) begin errors++; $display("[TB] FAIL lw_addr got %h exp 0040", mem_addr); end
    checks++; if (mem_be !== 4'b1111) begin errors++; $display("[TB] FAIL lw_be got %b exp 1111", mem_be); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL lw_busy got %b exp 0", req_ready); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL lw_early got %b exp 0", resp_valid); end
    step();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL lw_valid got %b exp 1", resp_valid); end
    checks++; if (resp_rdata !== 32'h89ABCDEF) begin errors++; $display("[TB] FAIL lw_data got %h exp 89abcdef", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("[TB] FAIL lw_err got %b exp 0", resp_err); end
    step();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("[TB] FAIL lw_after got %b exp 01", {resp_valid, req_ready}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL lw_data_clear got %h exp 0", resp_rdata); end
  endtask

  task automatic test_split_lw();
    mem[15'h40] = 32'h44332211;
    mem[15'h41] = 32'h88776655;
    send(1'b0, 3'b010, 32'h103, 32'h0);
    checks++; if ({mem_re, mem_addr, mem_be} !== {1'b1, 15'h40, 4'b1000}) begin errors++; $display("[TB] FAIL slw_beat0 got re=%b addr=%h be=%b exp re=1 addr=0040 be=1000", mem_re, mem_addr, mem_be); end
    step();
    checks++; if ({mem_re, mem_addr, mem_be} !== {1'b1, 15'h41, 4'b0111}) begin errors++; $display("[TB] FAIL slw_beat1 got re=%b addr=%h be=%b exp re=1 addr=0041 be=0111", mem_re, mem_addr, mem_be); end
    step();
    checks++; if ({mem_re, resp_valid} !== 2'b00) begin errors++; $display("[TB] FAIL slw_wait got %b exp 00", {mem_re, resp_valid}); end
    step();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL slw_valid got %b exp 1", resp_valid); end
    checks++; if (resp_rdata !== 32'h77665544) begin errors++; $display("[TB] FAIL slw_data got %h exp 77665544", resp_rdata); end
    step();
  endtask

  task automatic test_sub_loads();
    mem[15'h3F] = 32'h80F01234;
    send(1'b0, 3'b001, 32'h0FE, 32'h0);
    step(); step();
    checks++; if (resp_rdata !== 32'hFFFF80F0) begin errors++; $display("[TB] FAIL lh_data got %h exp ffff80f0", resp_rdata); end
    step();
    send(1'b0, 3'b101, 32'h0FE, 32'h0);
    step(); step();
    checks++; if (resp_rdata !== 32'h000080F0) begin errors++; $display("[TB] FAIL lhu_data got %h exp 000080f0", resp_rdata); end
    step();
    send(1'b0, 3'b000, 32'h0FF, 32'h0);
    step(); step();
    checks++; if (resp_rdata !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_data got %h exp ffffff80", resp_rdata); end
    step();
    send(1'b0, 3'b100, 32'h0FE, 32'h0);
    step(); step();
    checks++; if (resp_rdata !== 32'h000000F0) begin errors++; $display("[TB] FAIL lbu_data got %h exp 000000f0", resp_rdata); end
    step();
  endtask

  task automatic test_sh();
    mem[15'h0] = 32'h11111111;
    send(1'b1, 3'b001, 32'h001, 32'h0000BEEF);
    checks++; if ({mem_re, mem_we} !== 2'b01) begin errors++; $display("[TB] FAIL sh_strobes got %b exp 01", {mem_re, mem_we}); end
    checks++; if ({mem_addr, mem_be} !== {15'h0, 4'b0110}) begin errors++; $display("[TB] FAIL sh_addr_be got addr=%h be=%b exp addr=0000 be=0110", mem_addr, mem_be); end
    checks++; if (mem_wdata !== 32'h00BEEF00) begin errors++; $display("[TB] FAIL sh_wdata got %h exp 00beef00", mem_wdata); end
    step();
    checks++; if ({resp_valid, resp_err} !== 2'b10) begin errors++; $display("[TB] FAIL sh_resp got %b exp 10", {resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL sh_rdata got %h exp 0", resp_rdata); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL sh_we_drop got %b exp 0", mem_we); end
    step();
    checks++; if (mem[15'h0] !== 32'h11BEEF11) begin errors++; $display("[TB] FAIL sh_memory got %h exp 11beef11", mem[15'h0]); end
  endtask

  task automatic test_split_sw();
    send(1'b1, 3'b010, 32'h1FFFE, 32'hDDCCBBAA);
    checks++; if ({mem_we, mem_addr, mem_be} !== {1'b1, 15'h7FFF, 4'b1100}) begin errors++; $display("[TB] FAIL ssw_beat0 got we=%b addr=%h be=%b exp we=1 addr=7fff be=1100", mem_we, mem_addr, mem_be); end
    checks++; if (mem_wdata !== 32'hBBAA0000) begin errors++; $display("[TB] FAIL ssw_wdata0 got %h exp bbaa0000", mem_wdata); end
    step();
    checks++; if ({mem_we, mem_addr, mem_be} !== {1'b1, 15'h0000, 4'b0011}) begin errors++; $display("[TB] FAIL ssw_beat1 got we=%b addr=%h be=%b exp we=1 addr=0000 be=0011", mem_we, mem_addr, mem_be); end
    checks++; if (mem_wdata !== 32'h0000DDCC) begin errors++; $display("[TB] FAIL ssw_wdata1 got %h exp 0000ddcc", mem_wdata); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL ssw_early got %b exp 0", resp_valid); end
    step();
    checks++; if ({resp_valid, mem_we} !== 2'b10) begin errors++; $display("[TB] FAIL ssw_resp got %b exp 10", {resp_valid, mem_we}); end
    step();
  endtask

  task automatic test_illegal();
    send(1'b0, 3'b011, 32'h200, 32'h0);
    checks++; if ({resp_valid, resp_err} !== 2'b11) begin errors++; $display("[TB] FAIL ill_resp got %b exp 11", {resp_valid, resp_err}); end
    checks++; if ({mem_re, mem_we} !== 2'b00) begin errors++; $display("[TB] FAIL ill_strobes got %b exp 00", {mem_re, mem_we}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL ill_rdata got %h exp 0", resp_rdata); end
    step();
    checks++; if ({resp_valid, resp_err, req_ready} !== 3'b001) begin errors++; $display("[TB] FAIL ill_after got %b exp 001", {resp_valid, resp_err, req_ready}); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    send(1'b0, 3'b010, 32'h103, 32'h0);
    checks++; if (mem_re !== 1'b1) begin errors++; $display("[TB] FAIL mid_issue0 got %b exp 1", mem_re); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({mem_re, mem_be, resp_valid} !== 6'b0) begin errors++; $display("[TB] FAIL mid_cleared got re=%b be=%b valid=%b exp all 0", mem_re, mem_be, resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got %b exp 1", req_ready); end
    for (int i = 0; i < 6; i++) begin
      if (resp_valid || mem_re) bad++;
      step();
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL mid_quiet got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    int count = 0;
    mem[15'h40] = 32'h89ABCDEF;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_memop = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (resp_valid) begin
        count++;
        if (first < 0) first = k; else second = k;
      end
    end
    req_valid = 1'b0;
    checks++; if (count !== 2) begin errors++; $display("[TB] FAIL b2b_count got %0d exp 2", count); end
    checks++; if (first !== 3 || second !== 7) begin errors++; $display("[TB] FAIL b2b_timing got %0d,%0d exp 3,7", first, second); end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_aligned_lw();
    test_split_lw();
    test_sub_loads();
    test_sh();
    test_split_sw();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
